// File: rtl/i2c_line_conditioner.sv
// Pad-side I2C line conditioner: sync, deglitch, open-drain drive, bus events.
// Optional SCL low timeout (scl_timeout port) when I2C_LINE_COND_SCL_TIMEOUT_EN is defined.
module i2c_line_conditioner #(
   parameter int SYNC_STAGES        = 2,
   parameter int FILTER_LEN         = 4,
   parameter int BUS_FREE_CYCLES    = 480,
   parameter int SCL_TIMEOUT_CYCLES = 2400000
) (
   input  logic clk,
   input  logic sync_reset,
   input  logic sda_pad_in,
   input  logic scl_pad_in,
   input  logic sda_out,
   input  logic scl_out,
   output logic sda_pad_oe,
   output logic scl_pad_oe,
   output logic sda_in,
   output logic scl_in,
   output logic start_det,
   output logic stop_det,
   output logic bus_busy,
   output logic arb_lost,
   input  logic arb_clr,
   output logic stretch_active
`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
   ,
   output logic scl_timeout
`endif
);

   localparam int LAT = SYNC_STAGES + FILTER_LEN;
   localparam int FW  = $clog2(FILTER_LEN + 1);
   localparam int SW  = $clog2(LAT + 3);
   localparam int BW  = $clog2(BUS_FREE_CYCLES + 1);

   localparam logic [FW-1:0] F_MAX  = FW'(FILTER_LEN - 1);
   localparam logic [SW-1:0] S_THR  = SW'(LAT + 1);
   localparam logic [SW-1:0] S_FULL = SW'(LAT + 2);
   localparam logic [BW-1:0] B_FULL = BW'(BUS_FREE_CYCLES);
   localparam logic [BW-1:0] B_HIT  = BW'(BUS_FREE_CYCLES - 1);

   typedef enum logic {IDLE, BUSY} bus_state_t;

   logic [SYNC_STAGES-1:0] sync_q [2];
   logic [FW-1:0]          fcnt   [2];
   logic [1:0]             raw;
   logic [1:0]             filt;
   logic                   sda_q;
   logic                   scl_q;
   logic                   sda_oe_q;
   logic                   scl_oe_q;
   logic [LAT-1:0]         sda_dly;
   logic [BW-1:0]          free_cnt;
   logic [SW-1:0]          st_cnt;
   bus_state_t             state;
   bus_state_t             state_nx;
   logic                   lines_hi;
   logic                   free_hit;
   logic                   scl_rise;
   logic                   held;
   logic                   arb_set;
   logic                   to_force;

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         sync_q[0] <= '1;
         sync_q[1] <= '1;
      end else begin
         sync_q[0] <= {sync_q[0][SYNC_STAGES-2:0], sda_pad_in};
         sync_q[1] <= {sync_q[1][SYNC_STAGES-2:0], scl_pad_in};
      end
   end

   assign raw = {sync_q[1][SYNC_STAGES-1], sync_q[0][SYNC_STAGES-1]};

   // filtered level only moves after FILTER_LEN consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         filt    <= '1;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (raw[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == F_MAX) begin
               filt[i] <= raw[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + FW'(1);
            end
         end
      end
   end

   assign sda_in    = filt[0];
   assign scl_in    = filt[1];
   assign lines_hi  = sda_in & scl_in;
   assign start_det = sda_q & ~sda_in & scl_q & scl_in;
   assign stop_det  = ~sda_q & sda_in & scl_q & scl_in;
   assign scl_rise  = ~scl_q & scl_in;
   assign held      = scl_out & ~scl_in;
   assign free_hit  = lines_hi & (free_cnt >= B_HIT);
   assign arb_set   = scl_rise & bus_busy & sda_dly[LAT-1] & ~sda_in;

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         sda_q    <= 1'b1;
         scl_q    <= 1'b1;
         sda_oe_q <= 1'b0;
         scl_oe_q <= 1'b0;
         sda_dly  <= '1;
         free_cnt <= '0;
         st_cnt   <= '0;
         arb_lost <= 1'b0;
         state    <= IDLE;
      end else begin
         sda_q    <= sda_in;
         scl_q    <= scl_in;
         sda_oe_q <= ~sda_out;
         scl_oe_q <= ~scl_out;
         sda_dly  <= {sda_dly[LAT-2:0], sda_out};
         state    <= state_nx;
         if (!lines_hi || start_det) begin
            free_cnt <= '0;
         end else if (free_cnt != B_FULL) begin
            free_cnt <= free_cnt + BW'(1);
         end
         if (!held) begin
            st_cnt <= '0;
         end else if (st_cnt != S_FULL) begin
            st_cnt <= st_cnt + SW'(1);
         end
         if (arb_set) begin
            arb_lost <= 1'b1;
         end else if (arb_clr) begin
            arb_lost <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start_det) state_nx = BUSY;
         BUSY: if (!start_det && (stop_det || free_hit)) state_nx = IDLE;
      endcase
   end

`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
   localparam int TW = $clog2(SCL_TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_FULL = TW'(SCL_TIMEOUT_CYCLES);
   localparam logic [TW-1:0] T_HIT  = TW'(SCL_TIMEOUT_CYCLES - 1);

   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (sync_reset || scl_in) begin
         to_cnt      <= '0;
         scl_timeout <= 1'b0;
      end else begin
         if (to_cnt != T_FULL) to_cnt <= to_cnt + TW'(1);
         if (to_cnt == T_HIT) scl_timeout <= 1'b1;
      end
   end

   assign to_force = scl_timeout;
`else
   logic unused_timeout;
   assign unused_timeout = ^SCL_TIMEOUT_CYCLES;
   assign to_force = 1'b0;
`endif

   assign sda_pad_oe     = sda_oe_q & ~to_force;
   assign scl_pad_oe     = scl_oe_q & ~to_force;
   assign bus_busy       = (state == BUSY) & ~to_force;
   assign stretch_active = held & (st_cnt > S_THR);

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Bench for i2c_line_conditioner: directed bus scenarios plus random pad
// activity, all outputs compared every cycle against a history-based model.
module tb_i2c_line_conditioner;

   localparam int S    = 2;
   localparam int F    = 4;
   localparam int BFC  = 480;
   localparam int TO   = 100;
   localparam int LAT  = S + F;
   localparam int SLIM = LAT + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic sync_reset, sda_pad_in, scl_pad_in, sda_out, scl_out, arb_clr;
   logic sda_pad_oe, scl_pad_oe, sda_in, scl_in;
   logic start_det, stop_det, bus_busy, arb_lost, stretch_active;
`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
   logic scl_timeout;
`endif

   i2c_line_conditioner #(
      .SYNC_STAGES(S), .FILTER_LEN(F),
      .BUS_FREE_CYCLES(BFC), .SCL_TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .sync_reset(sync_reset),
      .sda_pad_in(sda_pad_in), .scl_pad_in(scl_pad_in),
      .sda_out(sda_out), .scl_out(scl_out),
      .sda_pad_oe(sda_pad_oe), .scl_pad_oe(scl_pad_oe),
      .sda_in(sda_in), .scl_in(scl_in),
      .start_det(start_det), .stop_det(stop_det),
      .bus_busy(bus_busy), .arb_lost(arb_lost),
      .arb_clr(arb_clr), .stretch_active(stretch_active)
`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
      , .scl_timeout(scl_timeout)
`endif
   );

   int checks = 0;
   int errors = 0;
   int n_start, n_stop, n_arb, n_str;

   bit h_sda[$];
   bit h_scl[$];
   bit o_hist[$];
   bit m_sda, m_scl, m_qsda, m_qscl;
   bit m_busy, m_arb, m_soe, m_coe, m_to;
   int free_run, st_run;
`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
   int low_run;
`endif

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function void m_reset();
      m_sda = 1; m_scl = 1; m_qsda = 1; m_qscl = 1;
      m_busy = 0; m_arb = 0; m_soe = 0; m_coe = 0; m_to = 0;
      free_run = 1;
      st_run = 0;
`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
      low_run = 0;
`endif
      h_sda.delete(); h_scl.delete(); o_hist.delete();
      for (int i = 0; i < S + F; i++) begin
         h_sda.push_back(1'b1);
         h_scl.push_back(1'b1);
      end
      for (int i = 0; i < LAT; i++) o_hist.push_back(1'b1);
   endfunction

   // filtered level flips once the F pad samples that have cleared the
   // synchroniser all disagree with it
   function automatic bit m_filt(input bit cur, input bit q[$]);
      bit all_diff = 1'b1;
      for (int i = S; i < S + F; i++)
         if (q[i] == cur) all_diff = 1'b0;
      return all_diff ? ~cur : cur;
   endfunction

   function void m_edge();
      bit st, sp, bo, arb_c, nb;
      if (sync_reset) begin
         m_reset();
         return;
      end
      st = m_qsda & ~m_sda & m_qscl & m_scl;
      sp = ~m_qsda & m_sda & m_qscl & m_scl;
      bo = m_busy & ~m_to;
      arb_c = ~m_qscl & m_scl & bo & o_hist[LAT-1] & ~m_sda;
      if (st) nb = 1'b1;
      else if (m_busy && (sp || free_run >= BFC)) nb = 1'b0;
      else nb = m_busy;
      m_arb = arb_c | (m_arb & ~arb_clr);
`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
      m_to = !m_scl && low_run >= TO;
`endif
      st_run = (scl_out && !m_scl) ? st_run + 1 : 0;
      m_soe = ~sda_out;
      m_coe = ~scl_out;
      m_qsda = m_sda;
      m_qscl = m_scl;
      h_sda.push_front(sda_pad_in); void'(h_sda.pop_back());
      h_scl.push_front(scl_pad_in); void'(h_scl.pop_back());
      o_hist.push_front(sda_out); void'(o_hist.pop_back());
      m_sda = m_filt(m_sda, h_sda);
      m_scl = m_filt(m_scl, h_scl);
      m_busy = nb;
      free_run = (m_sda && m_scl) ? free_run + 1 : 0;
`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
      low_run = m_scl ? 0 : low_run + 1;
`endif
   endfunction

   task automatic step();
      bit e_st, e_sp, e_str;
      @(posedge clk);
      #1;
      m_edge();
      e_st = m_qsda & ~m_sda & m_qscl & m_scl;
      e_sp = ~m_qsda & m_sda & m_qscl & m_scl;
      e_str = scl_out && !m_scl && st_run > SLIM;
      chk("sda_in", sda_in, m_sda);
      chk("scl_in", scl_in, m_scl);
      chk("sda_oe", sda_pad_oe, m_soe & ~m_to);
      chk("scl_oe", scl_pad_oe, m_coe & ~m_to);
      chk("start", start_det, e_st);
      chk("stop", stop_det, e_sp);
      chk("busy", bus_busy, m_busy & ~m_to);
      chk("arb", arb_lost, m_arb);
      chk("stretch", stretch_active, e_str);
`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
      chk("timeout", scl_timeout, m_to);
`endif
      if (start_det === 1'b1) n_start++;
      if (stop_det === 1'b1) n_stop++;
      if (arb_lost === 1'b1) n_arb++;
      if (stretch_active === 1'b1) n_str++;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   initial begin
      int lat;
      sync_reset = 1; sda_pad_in = 1; scl_pad_in = 1;
      sda_out = 1; scl_out = 1; arb_clr = 0;
      m_reset();
      idle(3);
      sync_reset = 0;
      step();
      chk("rst_busy", bus_busy, 0);
      chk("rst_oe", {sda_pad_oe, scl_pad_oe}, 0);

      // 3-cycle glitch never reaches sda_in
      n_start = 0;
      sda_pad_in = 0;
      idle(3);
      sda_pad_in = 1;
      idle(12);
      chk("glitch_start", n_start, 0);

      // 4-cycle pulse: START then STOP
      n_start = 0; n_stop = 0; lat = -1;
      sda_pad_in = 0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 4) sda_pad_in = 1;
         if (sda_in === 1'b0 && lat < 0) lat = i;
      end
      chk("start_lat", lat, 6);
      chk("start_cnt", n_start, 1);
      chk("stop_cnt", n_stop, 1);
      chk("stop_idle", bus_busy, 0);

      // START, SCL low, both lines high together, bus-free timeout
      sda_pad_in = 0; idle(10);
      chk("busy_set", bus_busy, 1);
      scl_pad_in = 0; idle(10);
      n_stop = 0; lat = -1;
      sda_pad_in = 1; scl_pad_in = 1;
      for (int i = 1; i <= 600; i++) begin
         step();
         if (bus_busy === 1'b0 && lat < 0) lat = i;
      end
      chk("free_lat", lat, 486);
      chk("free_nostop", n_stop, 0);

      // simultaneous fall is not a START
      n_start = 0;
      sda_pad_in = 0; scl_pad_in = 0; idle(12);
      sda_pad_in = 1; scl_pad_in = 1; idle(12);
      chk("simul_start", n_start, 0);

      // arbitration loss, clear, and set-beats-clear
      sda_pad_in = 0; idle(10);
      scl_pad_in = 0; idle(10);
      scl_pad_in = 1; idle(10);
      chk("arb_set", arb_lost, 1);
      idle(5);
      chk("arb_hold", arb_lost, 1);
      arb_clr = 1; step(); arb_clr = 0; step();
      chk("arb_clr", arb_lost, 0);
      scl_pad_in = 0; idle(10);
      n_arb = 0;
      arb_clr = 1; scl_pad_in = 1; idle(10);
      arb_clr = 0;
      chk("arb_prio", n_arb, 1);
      sda_pad_in = 1; idle(10);

      // registered pad drive, released by reset
      sda_out = 0; scl_out = 0; idle(3);
      chk("oe_drive", {sda_pad_oe, scl_pad_oe}, 3);
      sync_reset = 1; step();
      chk("oe_rst", {sda_pad_oe, scl_pad_oe}, 0);
      sync_reset = 0; sda_out = 1; scl_out = 1; idle(3);

      // clock stretch by another device
      n_str = 0;
      scl_pad_in = 0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (i == 20) scl_pad_in = 1;
      end
      chk("stretch_len", n_str, 12);

`ifdef I2C_LINE_COND_SCL_TIMEOUT_EN
      sda_out = 0; scl_out = 0; scl_pad_in = 0; idle(120);
      chk("to_flag", scl_timeout, 1);
      chk("to_oe", {sda_pad_oe, scl_pad_oe}, 0);
      sda_out = 1; scl_out = 1; scl_pad_in = 1; idle(10);
`endif

      // random pad and controller activity
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 5) == 0) sda_pad_in = $urandom_range(0, 1);
         if ($urandom_range(0, 5) == 0) scl_pad_in = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) sda_out = $urandom_range(0, 1);
         if ($urandom_range(0, 7) == 0) scl_out = $urandom_range(0, 1);
         arb_clr = ($urandom_range(0, 15) == 0);
         sync_reset = ($urandom_range(0, 900) == 0);
         step();
      end
      sync_reset = 0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
